// File: rtl/led_pattern_sequencer.sv
// Multi-mode LED pattern generator (rotate-left/right, bounce, fill/drain) with run-time prescaler.
// Optional one-shot behaviour is compiled in with `define LED_SEQ_ONESHOT_EN.
module led_pattern_sequencer #(
  parameter int unsigned MAX_LENGTH = 8,
  parameter int unsigned DIV_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [DIV_W-1:0]      div,
  input  logic                  run,
  output logic [MAX_LENGTH-1:0] led_out,
  output logic                  step,
  output logic                  wrap
);

  localparam int unsigned N = MAX_LENGTH;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    M_ROTL   = 2'b00,
    M_ROTR   = 2'b01,
    M_BOUNCE = 2'b10,
    M_FILL   = 2'b11
  } mode_e;

  mode_e            mode_q;
  logic [N-1:0]     led_q;
  logic [DIV_W-1:0] cnt_q;
  logic             dir_q;
  logic             step_q;
  logic             wrap_q;
  logic             halted;
  logic             tick;
  logic             onehot;
  logic             thermo;
  logic [N-1:0]     led_d;
  logic             dir_d;
  logic             wrap_d;

`ifdef LED_SEQ_ONESHOT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  function automatic logic [N-1:0] start_pat(input mode_e m);
    case (m)
      M_ROTR:  return MSB;
      M_FILL:  return '0;
      default: return ONE;
    endcase
  endfunction

  assign tick   = run && (cnt_q >= div) && !halted;
  assign onehot = (led_q != '0) && ((led_q & (led_q - ONE)) == '0);
  assign thermo = (led_q & (led_q + ONE)) == '0;

  // Any pattern that cannot occur in the current mode falls back to the start pattern.
  always_comb begin
    led_d  = start_pat(mode_q);
    dir_d  = 1'b1;
    wrap_d = 1'b0;
    case (mode_q)
      M_ROTL: if (onehot) begin
        led_d  = {led_q[N-2:0], led_q[N-1]};
        dir_d  = dir_q;
        wrap_d = (led_d == ONE);
      end
      M_ROTR: if (onehot) begin
        led_d  = {led_q[0], led_q[N-1:1]};
        dir_d  = dir_q;
        wrap_d = (led_d == MSB);
      end
      M_BOUNCE: if (onehot && !(dir_q && led_q[N-1]) && !(!dir_q && led_q[0])) begin
        if (dir_q) begin
          led_d = led_q << 1;
          dir_d = !led_d[N-1];
        end else begin
          led_d  = led_q >> 1;
          dir_d  = led_d[0];
          wrap_d = led_d[0];
        end
      end
      M_FILL: if (thermo) begin
        if (dir_q) begin
          led_d = {led_q[N-2:0], 1'b1};
          dir_d = !(&led_d);
        end else begin
          led_d  = led_q >> 1;
          dir_d  = !(|led_d);
          wrap_d = !(|led_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_ROTL;
      led_q  <= ONE;
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
`ifdef LED_SEQ_ONESHOT_EN
      halted_q <= 1'b0;
`endif
    end else if (mode != mode_q) begin
      mode_q <= mode_e'(mode);
      led_q  <= start_pat(mode_e'(mode));
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
`ifdef LED_SEQ_ONESHOT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      step_q <= tick;
      wrap_q <= tick && wrap_d;
      if (tick) begin
        led_q <= led_d;
        dir_q <= dir_d;
        cnt_q <= '0;
      end else if (run) begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
`ifdef LED_SEQ_ONESHOT_EN
      if (!run)
        halted_q <= 1'b0;
      else if (tick && wrap_d)
        halted_q <= 1'b1;
`endif
    end
  end

  assign led_out = led_q;
  assign step    = step_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed-step bench for led_pattern_sequencer (MAX_LENGTH=8, default build without one-shot).
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] div;
  logic       run;
  logic [7:0] led_out;
  logic       step;
  logic       wrap;

  int unsigned n_assert;
  int unsigned n_fail;

  typedef struct {
    logic [7:0] led;
    logic       stp;
    logic       wrp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  led_pattern_sequencer #(.MAX_LENGTH(8), .DIV_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .div     (div),
    .run     (run),
    .led_out (led_out),
    .step    (step),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, then clock and score the DUT's output.
  task automatic expect_cyc(input logic [7:0] l, input logic s, input logic w, input string tag);
    exp_t e;
    sb.push_back('{led: l, stp: s, wrp: w, tag: tag});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".led"},  led_out,     e.led);
      chk({e.tag, ".step"}, {7'd0, step}, {7'd0, e.stp});
      chk({e.tag, ".wrap"}, {7'd0, wrap}, {7'd0, e.wrp});
    end
  endtask

  task automatic hold(input logic [7:0] l, input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++)
      expect_cyc(l, 1'b0, 1'b0, $sformatf("%s_hold%0d", tag, i));
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] nxt;
    n_assert = 0;
    n_fail   = 0;
    rst  = 1'b1;
    mode = 2'b00;
    div  = 4'd0;
    run  = 1'b1;

    expect_cyc(8'h01, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // rotate-left, step every clock
    for (int k = 1; k <= 9; k++)
      expect_cyc(8'(8'h01 << (k % 8)), 1'b1, k == 8, $sformatf("rotl%0d", k));

    // bounce
    mode = 2'b10;
    expect_cyc(8'h01, 1'b0, 1'b0, "bounce_reload");
    for (int k = 1; k <= 15; k++) begin
      if (k <= 7)       nxt = 8'(8'h01 << k);
      else if (k <= 14) nxt = 8'(8'h01 << (14 - k));
      else              nxt = 8'h02;
      expect_cyc(nxt, 1'b1, k == 14, $sformatf("bounce%0d", k));
    end

    // fill/drain with div=2
    mode = 2'b11;
    div  = 4'd2;
    expect_cyc(8'h00, 1'b0, 1'b0, "fill_reload");
    prev = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      if (k <= 8) nxt = 8'((9'd1 << k) - 9'd1);
      else        nxt = 8'((9'd1 << (16 - k)) - 9'd1);
      hold(prev, 2, $sformatf("fill%0d", k));
      expect_cyc(nxt, 1'b1, k == 16, $sformatf("fill%0d", k));
      prev = nxt;
    end

    // back to rotate-left, then switch to rotate-right mid-count
    mode = 2'b00;
    expect_cyc(8'h01, 1'b0, 1'b0, "rotl_reload");
    hold(8'h01, 2, "rotl_a");
    expect_cyc(8'h02, 1'b1, 1'b0, "rotl_a");
    hold(8'h02, 2, "rotl_b");
    expect_cyc(8'h04, 1'b1, 1'b0, "rotl_b");
    hold(8'h04, 1, "rotl_c");
    mode = 2'b01;
    expect_cyc(8'h80, 1'b0, 1'b0, "rotr_reload");
    hold(8'h80, 2, "rotr_first");
    expect_cyc(8'h40, 1'b1, 1'b0, "rotr_first");

    // run low with div=3 and cnt=2
    div = 4'd3;
    hold(8'h40, 2, "pre_pause");
    run = 1'b0;
    hold(8'h40, 5, "paused");
    run = 1'b1;
    hold(8'h40, 1, "resume");
    expect_cyc(8'h20, 1'b1, 1'b0, "resume_adv");

    // reset mid-pattern, then mode=01 reload after release
    hold(8'h20, 1, "pre_rst");
    rst = 1'b1;
    expect_cyc(8'h01, 1'b0, 1'b0, "mid_rst");
    rst = 1'b0;
    expect_cyc(8'h80, 1'b0, 1'b0, "post_rst_reload");
    hold(8'h80, 3, "post_rst");
    expect_cyc(8'h40, 1'b1, 1'b0, "post_rst_adv");

    // rotate-right full period at div=0
    div = 4'd0;
    for (int k = 1; k <= 8; k++)
      expect_cyc(8'(8'h80 >> ((k + 1) % 8)), 1'b1, k == 7, $sformatf("rotr%0d", k));

    // lowering div mid-count ticks on the next enabled cycle
    div = 4'd3;
    hold(8'h40, 2, "div_lower");
    div = 4'd1;
    expect_cyc(8'h20, 1'b1, 1'b0, "div_lower_adv");

    // mode change is honoured while run is low
    run  = 1'b0;
    mode = 2'b10;
    expect_cyc(8'h01, 1'b0, 1'b0, "reload_run_low");
    hold(8'h01, 1, "run_low_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
